// File: rtl/cop_pkg.sv
// cop_pkg: definitions shared by the coprocessor dispatcher and the coprocessor.
//   - opcode constants for the coprocessor instruction group (110000..111000)
//   - bit positions of the instruction fields
//   - dispatcher state encoding
//   - is_legal(): range check on the 6-bit opcode
package cop_pkg;

  localparam logic [5:0] OP_ADD = 6'b110000;
  localparam logic [5:0] OP_SUB = 6'b110001;
  localparam logic [5:0] OP_MUL = 6'b110010;
  localparam logic [5:0] OP_DIV = 6'b110011;
  localparam logic [5:0] OP_CMP = 6'b110100;
  localparam logic [5:0] OP_REV = 6'b110101;
  localparam logic [5:0] OP_RND = 6'b110110;
  localparam logic [5:0] OP_LW  = 6'b110111;
  localparam logic [5:0] OP_SW  = 6'b111000;

  // Field LSBs; opcode is 6 bits, register fields are 5 bits.
  localparam int OPC_LSB = 26;
  localparam int FS_LSB  = 21;
  localparam int FT_LSB  = 16;
  localparam int FD_LSB  = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_ISSUE,
    ST_WAIT,
    ST_MEM_WR
  } state_e;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_SW);
  endfunction

endpackage

// File: rtl/cop_dispatch_if.sv
// cop_dispatch_if: command/response bundle between the dispatcher and the
// coprocessor.
//   master (dispatcher): drives cop_valid, cop_opcode, cop_rs1/rs2/rd, cop_wdata;
//                        receives cop_rdata, cop_done, cop_lt/gt/eq, cop_dbz.
//   slave  (coprocessor): the mirror image.
interface cop_dispatch_if;
  logic        cop_valid;
  logic [5:0]  cop_opcode;
  logic [4:0]  cop_rs1;
  logic [4:0]  cop_rs2;
  logic [4:0]  cop_rd;
  logic [31:0] cop_wdata;
  logic [31:0] cop_rdata;
  logic        cop_done;
  logic        cop_lt;
  logic        cop_gt;
  logic        cop_eq;
  logic        cop_dbz;

  modport master (
    output cop_valid, cop_opcode, cop_rs1, cop_rs2, cop_rd, cop_wdata,
    input  cop_rdata, cop_done, cop_lt, cop_gt, cop_eq, cop_dbz
  );

  modport slave (
    input  cop_valid, cop_opcode, cop_rs1, cop_rs2, cop_rd, cop_wdata,
    output cop_rdata, cop_done, cop_lt, cop_gt, cop_eq, cop_dbz
  );
endinterface

// File: rtl/cop_dispatch.sv
// cop_dispatch: accepts coprocessor instructions from the core, fetches load
// data from memory (lw), issues a one-cycle command to the coprocessor, waits
// for completion with a bounded timeout, and writes store data back (sw).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr/ea      instruction from the core, accepted in IDLE
//   instr_ready, busy         IDLE indication / core stall
//   cop (master modport)      coprocessor command and completion
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready  memory port
//   flag_lt/gt/eq             last cmp result; dbz_sticky + flag_clr
//   illegal_op, timeout       single-cycle error pulses
module cop_dispatch
  import cop_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic [31:0]          ea,
  output logic                 instr_ready,
  output logic                 busy,
  cop_dispatch_if.master       cop,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready,
  output logic                 flag_lt,
  output logic                 flag_gt,
  output logic                 flag_eq,
  output logic                 dbz_sticky,
  input  logic                 flag_clr,
  output logic                 illegal_op,
  output logic                 timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         state_q;
  logic [5:0]     op_q;
  logic [31:0]    ea_q;
  logic [4:0]     rs1_q, rs2_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    cwdata_q, mwdata_q;
  logic           lt_q, gt_q, eq_q, dbz_q;
  logic           ill_q, to_q;

  logic [5:0]     opc;
  logic [4:0]     fs, ft, fd;
  logic           unused_instr;

  assign opc = instr[OPC_LSB +: 6];
  assign fs  = instr[FS_LSB  +: 5];
  assign ft  = instr[FT_LSB  +: 5];
  assign fd  = instr[FD_LSB  +: 5];
  assign unused_instr = ^instr[FD_LSB-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      ea_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      cwdata_q <= '0;
      mwdata_q <= '0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      ill_q <= 1'b0;
      to_q  <= 1'b0;
      // A dbz set later in this block overrides the clear (set wins).
      if (flag_clr) dbz_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            if (!is_legal(opc)) begin
              ill_q <= 1'b1;
            end else begin
              op_q <= opc;
              ea_q <= ea;
              // Register fields are routed per instruction class at accept
              // time so the command bus is stable from ISSUE onward.
              case (opc)
                OP_LW:   begin rs1_q <= '0; rs2_q <= '0; rd_q <= ft; end
                OP_SW:   begin rs1_q <= ft; rs2_q <= '0; rd_q <= '0; end
                OP_REV:  begin rs1_q <= fs; rs2_q <= '0; rd_q <= fd; end
                default: begin rs1_q <= fs; rs2_q <= ft; rd_q <= fd; end
              endcase
              state_q <= (opc == OP_LW) ? ST_MEM_RD : ST_ISSUE;
            end
          end
        end

        ST_MEM_RD: begin
          if (mem_ready) begin
            cwdata_q <= mem_rdata;
            state_q  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // Completion on the final counted cycle still counts as done.
          if (cop.cop_done) begin
            if (op_q == OP_CMP) begin
              lt_q <= cop.cop_lt;
              gt_q <= cop.cop_gt;
              eq_q <= cop.cop_eq;
            end
            if ((op_q == OP_DIV || op_q == OP_REV) && cop.cop_dbz)
              dbz_q <= 1'b1;
            if (op_q == OP_SW) begin
              mwdata_q <= cop.cop_rdata;
              state_q  <= ST_MEM_WR;
            end else begin
              state_q  <= ST_IDLE;
            end
          end else if (cnt_q == CNT_LAST) begin
            to_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_MEM_WR: begin
          if (mem_ready) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode directly from the state register.
  assign instr_ready    = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign mem_read       = (state_q == ST_MEM_RD);
  assign mem_write      = (state_q == ST_MEM_WR);
  assign mem_addr       = ea_q;
  assign mem_wdata      = mwdata_q;

  assign cop.cop_valid  = (state_q == ST_ISSUE);
  assign cop.cop_opcode = op_q;
  assign cop.cop_rs1    = rs1_q;
  assign cop.cop_rs2    = rs2_q;
  assign cop.cop_rd     = rd_q;
  assign cop.cop_wdata  = cwdata_q;

  assign flag_lt        = lt_q;
  assign flag_gt        = gt_q;
  assign flag_eq        = eq_q;
  assign dbz_sticky     = dbz_q;
  assign illegal_op     = ill_q;
  assign timeout        = to_q;

endmodule

// File: tb/tb_cop_dispatch.sv
// Testbench for cop_dispatch: plays core, coprocessor and memory. Expected
// output events are queued when the stimulus that causes them is applied;
// a negedge monitor pops and compares whenever the DUT shows an event.
module tb_cop_dispatch;

  localparam int TO = 8;

  localparam int EV_CMD = 1;
  localparam int EV_MRD = 2;
  localparam int EV_MWR = 3;
  localparam int EV_ILL = 4;
  localparam int EV_TO  = 5;

  localparam logic [5:0] O_ADD = 6'h30;
  localparam logic [5:0] O_DIV = 6'h33;
  localparam logic [5:0] O_CMP = 6'h34;
  localparam logic [5:0] O_REV = 6'h35;
  localparam logic [5:0] O_LW  = 6'h37;
  localparam logic [5:0] O_SW  = 6'h38;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  fs, ft, fd;
    logic [31:0] ea, mdata, cdata;
    int          mem_lat, k;
    bit          no_done, junk, clr_done;
    bit          lt, gt, eq, dbz;
  } txn_t;

  typedef struct {
    int          kind;
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    bit          m_rs1, m_rs2, m_rd, m_wd;
    logic [31:0] addr, data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid;
  logic [31:0] instr, ea;
  logic        instr_ready, busy;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        flag_lt, flag_gt, flag_eq, dbz_sticky, flag_clr;
  logic        illegal_op, timeout;

  cop_dispatch_if cif();

  cop_dispatch #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .ea(ea),
    .instr_ready(instr_ready), .busy(busy),
    .cop(cif),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .flag_lt(flag_lt), .flag_gt(flag_gt), .flag_eq(flag_eq),
    .dbz_sticky(dbz_sticky), .flag_clr(flag_clr),
    .illegal_op(illegal_op), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  bit  m_lt, m_gt, m_eq, m_dbz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic ev_t ev0(input int kind);
    ev_t e;
    e.kind = kind; e.op = '0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.m_rs1 = 0; e.m_rs2 = 0; e.m_rd = 0; e.m_wd = 0;
    e.addr = '0; e.data = '0;
    return e;
  endfunction

  // Expected command from the register-mapping rules of each instruction class.
  function automatic ev_t cmd_ev(input txn_t t);
    ev_t e;
    e = ev0(EV_CMD);
    e.op = t.op;
    if (t.op == O_LW) begin
      e.rd = t.ft; e.m_rd = 1; e.m_wd = 1; e.data = t.mdata;
    end else if (t.op == O_SW) begin
      e.rs1 = t.ft; e.m_rs1 = 1;
    end else begin
      e.rs1 = t.fs; e.rd = t.fd;
      e.rs2 = (t.op == O_REV) ? 5'd0 : t.ft;
      e.m_rs1 = 1; e.m_rs2 = 1; e.m_rd = 1;
    end
    return e;
  endfunction

  // Monitor: every DUT-presented event must match the head of the queue.
  task automatic mon(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL unexpected_event: got kind %0d, expected no event", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          EV_CMD: begin
            chk("cop_opcode", {26'd0, cif.cop_opcode}, {26'd0, e.op});
            if (e.m_rs1) chk("cop_rs1", {27'd0, cif.cop_rs1}, {27'd0, e.rs1});
            if (e.m_rs2) chk("cop_rs2", {27'd0, cif.cop_rs2}, {27'd0, e.rs2});
            if (e.m_rd)  chk("cop_rd",  {27'd0, cif.cop_rd},  {27'd0, e.rd});
            if (e.m_wd)  chk("cop_wdata", cif.cop_wdata, e.data);
          end
          EV_MRD: chk("mem_rd_addr", mem_addr, e.addr);
          EV_MWR: begin
            chk("mem_wr_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.data);
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (cif.cop_valid === 1'b1)                      mon(EV_CMD);
      if (mem_read === 1'b1 && mem_ready === 1'b1)    mon(EV_MRD);
      if (mem_write === 1'b1 && mem_ready === 1'b1)   mon(EV_MWR);
      if (illegal_op === 1'b1)                         mon(EV_ILL);
      if (timeout === 1'b1)                            mon(EV_TO);
    end
  end

  // Event expected in the current cycle; the monitor must have consumed it
  // by the following negedge.
  task automatic expect_now(input ev_t e);
    exp_q.push_back(e);
    @(negedge clk); #1;
    chk("event_on_time", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_flags();
    chk("flag_lt", {31'd0, flag_lt}, {31'd0, m_lt});
    chk("flag_gt", {31'd0, flag_gt}, {31'd0, m_gt});
    chk("flag_eq", {31'd0, flag_eq}, {31'd0, m_eq});
    chk("dbz_sticky", {31'd0, dbz_sticky}, {31'd0, m_dbz});
  endtask

  task automatic idle_inputs();
    instr_valid = 0; instr = '0; ea = '0;
    mem_rdata = '0; mem_ready = 0; flag_clr = 0;
    cif.cop_done = 0; cif.cop_rdata = '0;
    cif.cop_lt = 0; cif.cop_gt = 0; cif.cop_eq = 0; cif.cop_dbz = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    exp_q.delete();
    m_lt = 0; m_gt = 0; m_eq = 0; m_dbz = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (instr_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (instr_ready !== 1'b1) begin
      chk("idle_within_budget", {31'd0, instr_ready}, 32'd1);
      do_reset();
    end
  endtask

  function automatic txn_t new_txn(input logic [5:0] op);
    txn_t t;
    t.op = op;
    t.fs = 5'($urandom); t.ft = 5'($urandom); t.fd = 5'($urandom);
    t.ea = $urandom; t.mdata = $urandom; t.cdata = $urandom;
    t.mem_lat = 1; t.k = 2;
    t.no_done = 0; t.junk = 0; t.clr_done = 0;
    t.lt = 0; t.gt = 0; t.eq = 0; t.dbz = 0;
    return t;
  endfunction

  task automatic run_txn(input txn_t t);
    ev_t e;
    bit  legal;
    legal = (t.op >= 6'h30) && (t.op <= 6'h38);
    wait_idle();
    instr_valid = 1;
    instr = {t.op, t.fs, t.ft, t.fd, 11'($urandom)};
    ea = t.ea;
    @(posedge clk); #1;
    instr_valid = 0;
    ea = $urandom;
    if (!legal) begin
      expect_now(ev0(EV_ILL));
      chk("idle_after_illegal", {31'd0, instr_ready}, 32'd1);
      check_flags();
      return;
    end
    if (t.op == O_LW) begin
      for (int i = 0; i < t.mem_lat; i++) begin
        chk("mem_read_held", {31'd0, mem_read}, 32'd1);
        @(posedge clk); #1;
      end
      mem_rdata = t.mdata; mem_ready = 1;
      e = ev0(EV_MRD); e.addr = t.ea;
      expect_now(e);
      @(posedge clk); #1;
      mem_ready = 0; mem_rdata = $urandom;
    end
    expect_now(cmd_ev(t));
    chk("busy_in_issue", {31'd0, busy}, 32'd1);
    if (t.junk) begin
      // completion while the command is still being issued must be ignored
      cif.cop_done = 1; cif.cop_dbz = 1; cif.cop_rdata = $urandom;
      cif.cop_lt = 1'($urandom); cif.cop_gt = 1'($urandom); cif.cop_eq = 1'($urandom);
    end
    @(posedge clk); #1;
    cif.cop_done = 0; cif.cop_dbz = 0;
    if (t.no_done) begin
      repeat (TO) begin @(posedge clk); #1; end
      expect_now(ev0(EV_TO));
    end else begin
      repeat (t.k) begin @(posedge clk); #1; end
      cif.cop_done = 1; cif.cop_rdata = t.cdata;
      cif.cop_lt = t.lt; cif.cop_gt = t.gt; cif.cop_eq = t.eq; cif.cop_dbz = t.dbz;
      flag_clr = t.clr_done;
      @(posedge clk); #1;
      cif.cop_done = 0; cif.cop_dbz = 0; flag_clr = 0;
      if (t.op == O_CMP) begin m_lt = t.lt; m_gt = t.gt; m_eq = t.eq; end
      if ((t.op == O_DIV || t.op == O_REV) && t.dbz) m_dbz = 1;
      else if (t.clr_done) m_dbz = 0;
      if (t.op == O_SW) begin
        for (int i = 0; i < t.mem_lat; i++) begin
          chk("mem_write_held", {31'd0, mem_write}, 32'd1);
          @(posedge clk); #1;
        end
        mem_ready = 1;
        e = ev0(EV_MWR); e.addr = t.ea; e.data = t.cdata;
        expect_now(e);
        @(posedge clk); #1;
        mem_ready = 0;
      end
    end
    chk("ready_after_op", {31'd0, instr_ready}, 32'd1);
    chk("busy_after_op", {31'd0, busy}, 32'd0);
    check_flags();
  endtask

  task automatic clr_pulse();
    flag_clr = 1;
    @(posedge clk); #1;
    flag_clr = 0;
    m_dbz = 0;
    check_flags();
  endtask

  initial begin
    txn_t t;
    idle_inputs();
    m_lt = 0; m_gt = 0; m_eq = 0; m_dbz = 0;
    rst = 1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 0;

    // reset state
    chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cop_valid", {31'd0, cif.cop_valid}, 32'd0);
    chk("rst_cop_opcode", {26'd0, cif.cop_opcode}, 32'd0);
    chk("rst_cop_wdata", cif.cop_wdata, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_illegal_op", {31'd0, illegal_op}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    check_flags();

    // add fd=3 fs=1 ft=2, done on the fifth WAIT cycle
    t = new_txn(O_ADD); t.fs = 1; t.ft = 2; t.fd = 3; t.k = 4; run_txn(t);
    // lw ft=5 from 0x100
    t = new_txn(O_LW); t.ft = 5; t.ea = 32'h100; t.mdata = 32'h3F80_0000; t.mem_lat = 2;
    run_txn(t);
    // sw ft=7 to 0x200
    t = new_txn(O_SW); t.ft = 7; t.ea = 32'h200; t.cdata = 32'h4000_0000; run_txn(t);
    // cmp lt, then div dbz, then clear
    t = new_txn(O_CMP); t.lt = 1; run_txn(t);
    t = new_txn(O_DIV); t.dbz = 1; run_txn(t);
    clr_pulse();
    // rev dbz with a simultaneous clear: set wins
    t = new_txn(O_REV); t.dbz = 1; t.clr_done = 1; run_txn(t);
    // timeout, then done on the last allowed cycle
    t = new_txn(O_ADD); t.no_done = 1; run_txn(t);
    t = new_txn(O_ADD); t.k = TO - 1; run_txn(t);
    // illegal opcode 000000
    t = new_txn(6'h00); run_txn(t);

    // reset in the middle of WAIT
    t = new_txn(O_ADD);
    wait_idle();
    instr_valid = 1; instr = {t.op, t.fs, t.ft, t.fd, 11'd0}; ea = t.ea;
    @(posedge clk); #1;
    instr_valid = 0;
    expect_now(cmd_ev(t));
    repeat (2) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_instr_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cop_valid", {31'd0, cif.cop_valid}, 32'd0);
    chk("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("midrst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    rst = 0;
    exp_q.delete();
    m_lt = 0; m_gt = 0; m_eq = 0; m_dbz = 0;
    check_flags();

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        t = new_txn(6'h00);
        do t.op = 6'($urandom_range(0, 63)); while (t.op >= 6'h30 && t.op <= 6'h38);
      end else begin
        t = new_txn(6'h30 + 6'($urandom_range(0, 8)));
      end
      t.mem_lat  = $urandom_range(0, 3);
      t.k        = $urandom_range(0, TO - 1);
      t.no_done  = ($urandom_range(0, 9) == 0);
      t.junk     = ($urandom_range(0, 9) < 3);
      t.clr_done = ($urandom_range(0, 9) < 3);
      t.lt  = 1'($urandom); t.gt = 1'($urandom); t.eq = 1'($urandom);
      t.dbz = 1'($urandom);
      run_txn(t);
      if ($urandom_range(0, 9) < 2) clr_pulse();
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
